// File: rtl/pwm_pkg.sv
// Shared constants for the PWM timebase, generator and register block.
// Widths, direction encoding and counter state encoding.
package pwm_pkg;

  localparam int COUNT_W_DEF = 16;
  localparam int PRESC_W_DEF = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_counter_prescaler.sv
// Clock prescaler for the PWM timebase.
// Counts 0..load and pulses tick combinationally on the terminal count.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] load,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] ONE = 1;

  logic [PRESC_W-1:0] psc;

  assign tick = en && !clr && (psc == load);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (clr) begin
      psc <= '0;
    end else if (en) begin
      psc <= tick ? '0 : psc + ONE;
    end
  end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: prescaled up/down counter with period-boundary shadows.
// Feeds count_val to pwm_gen and a wrap pulse to the register block.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               count_clr,
  input  logic [COUNT_W-1:0] period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               dir_down,
  output logic [COUNT_W-1:0] count_val,
  output logic               tick,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] ONE = 1;

  state_e             state;
  logic [COUNT_W-1:0] period_s;
  logic [PRESC_W-1:0] prescale_s;
  logic               dir_s;

  logic               psc_en;
  logic               psc_clr;
  logic               psc_tick;

  logic [COUNT_W-1:0] last_val;
  logic [COUNT_W-1:0] reload_val;
  logic [COUNT_W-1:0] next_val;
  logic               at_end;

  function automatic logic [COUNT_W-1:0] start_val(
    input logic               d,
    input logic [COUNT_W-1:0] p
  );
    if (d == DIR_DOWN && p != '0) begin
      return p - ONE;
    end
    return '0;
  endfunction

  // period 0 collapses to period 1 so the counter never runs away
  assign last_val   = (period_s == '0) ? '0 : period_s - ONE;
  assign reload_val = start_val(dir_down, period);

  always_comb begin
    at_end   = 1'b0;
    next_val = count_val;
    unique case (1'b1)
      (dir_s == DIR_DOWN): begin
        at_end   = (count_val == '0);
        next_val = count_val - ONE;
      end
      default: begin
        at_end   = (count_val >= last_val);
        next_val = count_val + ONE;
      end
    endcase
  end

  assign psc_en  = (state == RUN) && en && !count_clr;
  assign psc_clr = count_clr || (state == IDLE);

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (psc_en),
    .clr   (psc_clr),
    .load  (prescale_s),
    .tick  (psc_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_s   <= '0;
      prescale_s <= '0;
      dir_s      <= DIR_UP;
      count_val  <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else if (count_clr) begin
      state      <= IDLE;
      period_s   <= period;
      prescale_s <= prescale;
      dir_s      <= dir_down;
      count_val  <= reload_val;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          period_s   <= period;
          prescale_s <= prescale;
          dir_s      <= dir_down;
          count_val  <= reload_val;
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (psc_tick) begin
            tick <= 1'b1;
            if (at_end) begin
              wrap       <= 1'b1;
              period_s   <= period;
              prescale_s <= prescale;
              dir_s      <= dir_down;
              count_val  <= reload_val;
            end else begin
              count_val <= next_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
